// File: rtl/fetch_queue_pkg.sv
// Shared front-end types: the buffered {instruction, pc} entry and the NOP encoding.
package core;

    localparam int DATA_WIDTH = 32;
    localparam int ADDR_WIDTH = 32;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] instr;
        logic [ADDR_WIDTH-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue_sat_counter.sv
// Saturating up-counter with synchronous reset; reusable for performance counters.
module sat_counter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    output logic [WIDTH-1:0] cnt_o
);

    logic [WIDTH-1:0] cnt_q;
    logic [WIDTH-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (inc_i && (cnt_q != {WIDTH{1'b1}})) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/fetch_queue.sv
// Fetch-to-decode {instr, pc} FIFO with single-cycle flush and a decode-starvation counter.
module fetch_queue #(
    parameter int DATA_WIDTH = core::DATA_WIDTH,
    parameter int ADDR_WIDTH = core::ADDR_WIDTH,
    parameter int DEPTH      = 4,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush_i,
    input  logic                       enq_valid_i,
    output logic                       enq_ready_o,
    input  logic [DATA_WIDTH-1:0]      enq_instr_i,
    input  logic [ADDR_WIDTH-1:0]      enq_pc_i,
    output logic                       deq_valid_o,
    input  logic                       deq_ready_i,
    output logic [DATA_WIDTH-1:0]      deq_instr_o,
    output logic [ADDR_WIDTH-1:0]      deq_pc_o,
    output logic [$clog2(DEPTH):0]     count_o,
    output logic [CNT_WIDTH-1:0]       starve_cnt_o
);
    import core::*;

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    fetch_entry_t  mem_q [DEPTH];
    fetch_entry_t  head;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          full, empty, enq_fire, deq_fire;

    // Handshake qualifiers depend only on registered count: no enq->deq bypass.
    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign enq_fire = enq_valid_i && !full;
    assign deq_fire = deq_ready_i && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (enq_fire) wr_ptr_d = wr_ptr_q + 1'b1;
            if (deq_fire) rd_ptr_d = rd_ptr_q + 1'b1;
            case ({enq_fire, deq_fire})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is deliberately left unreset; the output gating hides stale contents.
    always_ff @(posedge clk) begin
        if (!rst && !flush_i && enq_fire) begin
            mem_q[wr_ptr_q] <= '{instr: enq_instr_i, pc: enq_pc_i};
        end
    end

    assign head        = mem_q[rd_ptr_q];
    assign enq_ready_o = !full;
    assign deq_valid_o = !empty;
    assign count_o     = count_q;
    assign deq_instr_o = deq_valid_o ? head.instr : DATA_WIDTH'(NOP_INSTR);
    assign deq_pc_o    = deq_valid_o ? head.pc    : '0;

    sat_counter #(
        .WIDTH(CNT_WIDTH)
    ) u_starve_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc_i(deq_ready_i && empty),
        .cnt_o(starve_cnt_o)
    );

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: directed vector table, hand sequences, and random traffic vs a queue model.
module tb_fetch_queue;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        ev;
    logic        enq_ready;
    logic [31:0] einstr;
    logic [31:0] epc;
    logic        deq_valid;
    logic        dr;
    logic [31:0] dinstr;
    logic [31:0] dpc;
    logic [2:0]  count;
    logic [31:0] starve;

    logic        dr2;
    logic        enq_ready2;
    logic        deq_valid2;
    logic [31:0] dinstr2;
    logic [31:0] dpc2;
    logic [2:0]  count2;
    logic [2:0]  starve2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fetch_queue dut (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (flush),
        .enq_valid_i (ev),
        .enq_ready_o (enq_ready),
        .enq_instr_i (einstr),
        .enq_pc_i    (epc),
        .deq_valid_o (deq_valid),
        .deq_ready_i (dr),
        .deq_instr_o (dinstr),
        .deq_pc_o    (dpc),
        .count_o     (count),
        .starve_cnt_o(starve)
    );

    fetch_queue #(.CNT_WIDTH(3)) dut_sat (
        .clk         (clk),
        .rst         (rst),
        .flush_i     (1'b0),
        .enq_valid_i (1'b0),
        .enq_ready_o (enq_ready2),
        .enq_instr_i (32'h0),
        .enq_pc_i    (32'h0),
        .deq_valid_o (deq_valid2),
        .deq_ready_i (dr2),
        .deq_instr_o (dinstr2),
        .deq_pc_o    (dpc2),
        .count_o     (count2),
        .starve_cnt_o(starve2)
    );

    typedef struct {
        logic        fl;
        logic        ev;
        logic [31:0] epc;
        logic        dr;
        int          cnt;
        logic        val;
        logic        rdy;
        logic [31:0] pc;
    } vec_t;

    vec_t tbl[21];

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    ent_t model_q[$];
    int   model_starve;

    function automatic logic [31:0] ins(input logic [31:0] pc);
        return pc ^ 32'hC0DE_0003;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_valid"}, 64'(deq_valid), 64'd0);
        chk({tag, "_ready"}, 64'(enq_ready), 64'd1);
        chk({tag, "_count"}, 64'(count),     64'd0);
        chk({tag, "_instr"}, 64'(dinstr),    64'(NOP));
        chk({tag, "_pc"},    64'(dpc),       64'd0);
        chk({tag, "_starve"},64'(starve),    64'd0);
    endtask

    initial begin
        // state before each row's edge: fill, hold a 5th, drain, concurrent at 2, flush at 3
        tbl[0]  = '{0, 1, 32'h00, 0, 0, 0, 1, 32'h00};
        tbl[1]  = '{0, 1, 32'h04, 0, 1, 1, 1, 32'h00};
        tbl[2]  = '{0, 1, 32'h08, 0, 2, 1, 1, 32'h00};
        tbl[3]  = '{0, 1, 32'h0C, 0, 3, 1, 1, 32'h00};
        tbl[4]  = '{0, 1, 32'h10, 0, 4, 1, 0, 32'h00};
        tbl[5]  = '{0, 1, 32'h10, 1, 4, 1, 0, 32'h00};
        tbl[6]  = '{0, 0, 32'h00, 1, 3, 1, 1, 32'h04};
        tbl[7]  = '{0, 0, 32'h00, 1, 2, 1, 1, 32'h08};
        tbl[8]  = '{0, 0, 32'h00, 1, 1, 1, 1, 32'h0C};
        tbl[9]  = '{0, 0, 32'h00, 0, 0, 0, 1, 32'h00};
        tbl[10] = '{0, 1, 32'h20, 0, 0, 0, 1, 32'h00};
        tbl[11] = '{0, 1, 32'h24, 0, 1, 1, 1, 32'h20};
        tbl[12] = '{0, 1, 32'h28, 1, 2, 1, 1, 32'h20};
        tbl[13] = '{0, 1, 32'h2C, 1, 2, 1, 1, 32'h24};
        tbl[14] = '{0, 1, 32'h30, 1, 2, 1, 1, 32'h28};
        tbl[15] = '{0, 0, 32'h00, 0, 2, 1, 1, 32'h2C};
        tbl[16] = '{0, 1, 32'h34, 0, 2, 1, 1, 32'h2C};
        tbl[17] = '{1, 1, 32'h40, 1, 3, 1, 1, 32'h2C};
        tbl[18] = '{0, 1, 32'h80, 0, 0, 0, 1, 32'h00};
        tbl[19] = '{0, 0, 32'h00, 1, 1, 1, 1, 32'h80};
        tbl[20] = '{0, 0, 32'h00, 0, 0, 0, 1, 32'h00};

        rst = 1; flush = 0; ev = 0; einstr = 0; epc = 0; dr = 0; dr2 = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_reset_vals("reset");
        rst = 0;

        for (int i = 0; i < 21; i++) begin
            flush = tbl[i].fl; ev = tbl[i].ev; epc = tbl[i].epc; einstr = ins(tbl[i].epc); dr = tbl[i].dr;
            #1;
            chk($sformatf("tbl%0d_count", i), 64'(count),     64'(tbl[i].cnt));
            chk($sformatf("tbl%0d_valid", i), 64'(deq_valid), 64'(tbl[i].val));
            chk($sformatf("tbl%0d_ready", i), 64'(enq_ready), 64'(tbl[i].rdy));
            chk($sformatf("tbl%0d_pc", i),    64'(dpc),       64'(tbl[i].pc));
            chk($sformatf("tbl%0d_instr", i), 64'(dinstr),    64'(tbl[i].val ? ins(tbl[i].pc) : NOP));
            @(posedge clk);
            #1;
        end
        flush = 0; ev = 0; dr = 0;

        // wrap: 10 back-to-back enq/deq pairs through DEPTH=4 storage
        for (int i = 0; i <= 10; i++) begin
            ev = (i < 10); epc = 32'(4 * i); einstr = ins(32'(4 * i)); dr = 1;
            #1;
            chk($sformatf("wrap%0d_count", i), 64'(count), (i == 0) ? 64'd0 : 64'd1);
            chk($sformatf("wrap%0d_valid", i), 64'(deq_valid), (i == 0) ? 64'd0 : 64'd1);
            if (i > 0) chk($sformatf("wrap%0d_pc", i), 64'(dpc), 64'(4 * (i - 1)));
            @(posedge clk);
            #1;
        end
        ev = 0; dr = 0;
        chk("wrap_end_count", 64'(count), 64'd0);

        // starvation, plus saturation of the 3-bit instance
        rst = 1;
        tick();
        rst = 0;
        dr = 1; dr2 = 1;
        repeat (5) tick();
        chk("starve5", 64'(starve), 64'd5);
        repeat (5) tick();
        chk("sat10", 64'(starve2), 64'd7);
        repeat (2) tick();
        chk("sat_hold", 64'(starve2), 64'd7);
        chk("starve12", 64'(starve), 64'd12);
        dr = 0; dr2 = 0;

        // reset mid-operation overrides flush and handshakes
        ev = 1; epc = 32'h100; einstr = ins(32'h100);
        tick();
        epc = 32'h104; einstr = ins(32'h104);
        tick();
        chk("mid_count", 64'(count), 64'd2);
        rst = 1; flush = 1; dr = 1; epc = 32'h108;
        tick();
        chk_reset_vals("midrst");
        rst = 0; flush = 0; ev = 0; dr = 0;

        // random traffic vs queue model: fill-biased, then drain-biased
        model_starve = 0;
        for (int c = 0; c < 400; c++) begin
            int   sz;
            ent_t e;
            flush  = ($urandom_range(0, 15) == 0);
            ev     = ($urandom_range(0, 3) < ((c < 200) ? 3 : 1));
            dr     = ($urandom_range(0, 3) < ((c < 200) ? 1 : 3));
            epc    = $urandom;
            einstr = $urandom;
            #1;
            sz = model_q.size();
            chk("rnd_count", 64'(count),     64'(sz));
            chk("rnd_valid", 64'(deq_valid), 64'(sz > 0));
            chk("rnd_ready", 64'(enq_ready), 64'(sz < 4));
            chk("rnd_pc",    64'(dpc),       (sz > 0) ? 64'(model_q[0].pc)    : 64'd0);
            chk("rnd_instr", 64'(dinstr),    (sz > 0) ? 64'(model_q[0].instr) : 64'(NOP));
            chk("rnd_starve",64'(starve),    64'(model_starve));
            if (dr && sz == 0) model_starve++;
            if (flush) begin
                model_q.delete();
            end else begin
                if (dr && sz > 0) void'(model_q.pop_front());
                if (ev && sz < 4) begin
                    e.pc = epc; e.instr = einstr;
                    model_q.push_back(e);
                end
            end
            @(posedge clk);
            #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
